// File: rtl/ara_pkg.sv
// Shared types and constants for the vector mask-unit operand router.
//   mask_fu_idx_t / mask_fu_e : index of a functional unit feeding the mask unit
//   MaskRouterDepth           : default entries per per-FU operand buffer
//   NrMaskFUs                 : default number of FUs feeding the mask unit
//   wrap_inc                  : pointer increment with wrap at an arbitrary depth
package ara_pkg;

  typedef logic [1:0] mask_fu_idx_t;

  typedef enum mask_fu_idx_t {
    MaskFUAlu   = 2'd0,
    MaskFUMFpu  = 2'd1,
    MaskFUSlide = 2'd2
  } mask_fu_e;

  localparam int unsigned MaskRouterDepth = 2;
  localparam int unsigned NrMaskFUs       = 3;

  // Increment a buffer pointer, wrapping to 0 after depth-1 (any depth, not just powers of two).
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return ((ptr + 1) >= depth) ? 0 : (ptr + 1);
  endfunction

endpackage

// File: rtl/vfu_mask_fifo.sv
// Single-channel operand FIFO with occupancy count.
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   flush_i           : synchronous clear, wins over push/pop
//   push_i, data_i    : write one entry (caller guarantees not full)
//   pop_i             : drop head entry (caller guarantees not empty)
//   data_o            : current head entry (registered storage, no fall-through)
//   count_o, full_o   : occupancy 0..Depth and full flag
module vfu_mask_fifo
  import ara_pkg::*;
#(
  parameter int unsigned Depth     = MaskRouterDepth,
  parameter int unsigned DataWidth = 64,
  localparam int unsigned PtrW     = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW     = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] data_o,
  output logic [CntW-1:0]      count_o,
  output logic                 full_o
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] mem_d [Depth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;

  // Next-state: flush clears pointers and count; otherwise push/pop update independently.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = PtrW'(wrap_inc(32'(wr_ptr_q), Depth));
      end
      if (pop_i) begin
        rd_ptr_d = PtrW'(wrap_inc(32'(rd_ptr_q), Depth));
      end
      if (push_i && !pop_i) begin
        count_d = count_q + CntW'(1);
      end else if (!push_i && pop_i) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  // Control state: pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: the count gates every read.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CntW'(Depth));

endmodule

// File: rtl/vfu_mask_router.sv
// Routes result operands from NrFUs functional units to the mask unit.
// Each FU owns a Depth-entry FIFO; the mask unit selects which FIFO it drains.
// Ports:
//   clk_i, rst_i                          : clock, asynchronous active-high reset
//   fu_operand_i / _valid_i / _ready_o    : per-FU operand push handshake
//   mask_operand_fu_i                     : FU index the mask unit is waiting on
//   mask_operand_o / _valid_o / _ready_i  : operand stream to the mask unit
//   flush_i                               : synchronous clear of all FIFOs
//   fu_mask_ready_i, mask_ready_o         : per-FU mask readiness, OR-ed back
//   starve_cnt_o                          : cycles the mask unit waited on an empty
//                                           channel; only counts when the macro
//                                           VFU_MASK_ROUTER_STATS_EN is defined,
//                                           otherwise tied to 0
module vfu_mask_router
  import ara_pkg::*;
#(
  parameter int unsigned NrFUs     = NrMaskFUs,
  parameter int unsigned Depth     = MaskRouterDepth,
  parameter int unsigned DataWidth = 64,
  localparam int unsigned SelW     = (NrFUs > 1) ? $clog2(NrFUs) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NrFUs-1:0][DataWidth-1:0] fu_operand_i,
  input  logic [NrFUs-1:0]                fu_operand_valid_i,
  output logic [NrFUs-1:0]                fu_operand_ready_o,
  input  logic [SelW-1:0]                 mask_operand_fu_i,
  output logic [DataWidth-1:0]            mask_operand_o,
  output logic                            mask_operand_valid_o,
  input  logic                            mask_operand_ready_i,
  input  logic                            flush_i,
  input  logic [NrFUs-1:0]                fu_mask_ready_i,
  output logic                            mask_ready_o,
  output logic [31:0]                     starve_cnt_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [DataWidth-1:0] head  [NrFUs];
  logic [CntW-1:0]      count [NrFUs];
  logic [NrFUs-1:0]     full;
  logic [NrFUs-1:0]     push;
  logic [NrFUs-1:0]     pop;

  for (genvar g = 0; g < NrFUs; g++) begin : gen_fifo
    vfu_mask_fifo #(
      .Depth     (Depth),
      .DataWidth (DataWidth)
    ) i_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .push_i  (push[g]),
      .data_i  (fu_operand_i[g]),
      .pop_i   (pop[g]),
      .data_o  (head[g]),
      .count_o (count[g]),
      .full_o  (full[g])
    );
  end

  // Push side: accept while not full; flush and reset both block new entries.
  always_comb begin
    fu_operand_ready_o = '0;
    push               = '0;
    for (int i = 0; i < NrFUs; i++) begin
      fu_operand_ready_o[i] = !full[i] && !flush_i && !rst_i;
      push[i]               = fu_operand_valid_i[i] && fu_operand_ready_o[i];
    end
  end

  // Pop side: only the addressed FIFO is visible or popped; an out-of-range index matches nothing.
  always_comb begin
    mask_operand_valid_o = 1'b0;
    mask_operand_o       = '0;
    pop                  = '0;
    for (int i = 0; i < NrFUs; i++) begin
      if ((mask_operand_fu_i == SelW'(i)) && (count[i] != '0) && !rst_i) begin
        mask_operand_valid_o = 1'b1;
        mask_operand_o       = head[i];
        pop[i]               = mask_operand_ready_i && !flush_i;
      end
    end
  end

  assign mask_ready_o = |fu_mask_ready_i;

`ifdef VFU_MASK_ROUTER_STATS_EN
  logic [31:0] starve_cnt_q, starve_cnt_d;

  // Count cycles the mask unit is ready but has nothing to consume; saturates.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (mask_operand_ready_i && !mask_operand_valid_o && (starve_cnt_q != 32'hFFFF_FFFF)) begin
      starve_cnt_d = starve_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign starve_cnt_o = starve_cnt_q;
`else
  assign starve_cnt_o = '0;
`endif

endmodule

// File: tb/tb_vfu_mask_router.sv
// Scoreboard bench for vfu_mask_router (NrFUs=3, Depth=2, DataWidth=64).
// The driver issues stimulus and commits accepted operands into per-FU expected queues;
// a negedge monitor compares DUT outputs against the queues and retires popped entries.
module tb_vfu_mask_router;

  localparam int NF = 3;
  localparam int DP = 2;
  localparam int DW = 64;
`ifdef VFU_MASK_ROUTER_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NF-1:0][DW-1:0]  fu_operand;
  logic [NF-1:0]          fu_valid;
  logic [NF-1:0]          fu_ready;
  logic [1:0]             sel;
  logic [DW-1:0]          m_data;
  logic                   m_valid;
  logic                   m_ready;
  logic                   flush;
  logic [NF-1:0]          fu_mask_ready;
  logic                   mask_ready;
  logic [31:0]            starve_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] exp_q [NF][$];
  logic [31:0]   starve_exp;
  bit            pend_v [NF];
  logic [DW-1:0] pend_d [NF];

  vfu_mask_router #(.NrFUs(NF), .Depth(DP), .DataWidth(DW)) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .fu_operand_i         (fu_operand),
    .fu_operand_valid_i   (fu_valid),
    .fu_operand_ready_o   (fu_ready),
    .mask_operand_fu_i    (sel),
    .mask_operand_o       (m_data),
    .mask_operand_valid_o (m_valid),
    .mask_operand_ready_i (m_ready),
    .flush_i              (flush),
    .fu_mask_ready_i      (fu_mask_ready),
    .mask_ready_o         (mask_ready),
    .starve_cnt_o         (starve_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs against the reference queues, then apply this cycle's pop/flush.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_ready", 64'(fu_ready), 64'(0));
        chk("rst_valid", 64'(m_valid), 64'(0));
        chk("rst_data", m_data, 64'(0));
        chk("rst_starve", 64'(starve_cnt), 64'(0));
        starve_exp = 32'd0;
      end else begin
        bit ev;
        ev = (int'(sel) < NF) && (exp_q[sel].size() > 0);
        for (int i = 0; i < NF; i++) begin
          chk($sformatf("ready%0d", i), 64'(fu_ready[i]),
              64'((exp_q[i].size() < DP) && !flush));
        end
        chk("valid", 64'(m_valid), 64'(ev));
        if (ev) chk("data", m_data, exp_q[sel][0]);
        else if (int'(sel) >= NF) chk("bad_sel_data", m_data, 64'(0));
        chk("starve", 64'(starve_cnt), Stats ? 64'(starve_exp) : 64'(0));
        chk("mask_ready", 64'(mask_ready), 64'(|fu_mask_ready));
        if (flush) begin
          for (int i = 0; i < NF; i++) exp_q[i].delete();
        end else if (ev && m_ready) begin
          void'(exp_q[sel].pop_front());
        end
        if (m_ready && !ev && starve_exp != 32'hFFFF_FFFF) starve_exp = starve_exp + 32'd1;
      end
    end
  end

  // One clock of stimulus; accepted pushes enter the scoreboard at the edge.
  task automatic cyc(input logic [2:0] v, input logic [63:0] d0, input logic [63:0] d1,
                     input logic [63:0] d2, input logic [1:0] s, input logic r, input logic f);
    fu_valid      = v;
    fu_operand[0] = d0;
    fu_operand[1] = d1;
    fu_operand[2] = d2;
    sel           = s;
    m_ready       = r;
    flush         = f;
    fu_mask_ready = 3'($urandom_range(0, 7));
    for (int i = 0; i < NF; i++) begin
      pend_v[i] = v[i] && !f && !rst && (exp_q[i].size() < DP);
      pend_d[i] = fu_operand[i];
    end
    @(posedge clk);
    for (int i = 0; i < NF; i++) if (pend_v[i] && !rst) exp_q[i].push_back(pend_d[i]);
    #1;
  endtask

  // Asynchronous reset pulse: everything buffered is dropped.
  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NF; i++) begin
      exp_q[i].delete();
      pend_v[i] = 1'b0;
    end
    starve_exp = 32'd0;
    #1;
    chk("async_rst_valid", 64'(m_valid), 64'(0));
    chk("async_rst_starve", 64'(starve_cnt), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] r0, r1, r2;
    rst = 1'b1; fu_operand = '0; fu_valid = '0; sel = '0; m_ready = 1'b0;
    flush = 1'b0; fu_mask_ready = '0; starve_exp = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Two operands on FU1 drain in order, then channel goes empty.
    cyc(3'b010, 0, 64'hA1, 0, 2'd1, 1'b0, 1'b0);
    cyc(3'b010, 0, 64'hA2, 0, 2'd1, 1'b0, 1'b0);
    repeat (3) cyc(3'b000, 0, 0, 0, 2'd1, 1'b1, 1'b0);

    // Full FU0 back-pressures; one pop reopens it.
    cyc(3'b001, 64'hC1, 0, 0, 2'd0, 1'b0, 1'b0);
    cyc(3'b001, 64'hC2, 0, 0, 2'd0, 1'b0, 1'b0);
    cyc(3'b001, 64'hC3, 0, 0, 2'd0, 1'b0, 1'b0);
    cyc(3'b000, 0, 0, 0, 2'd0, 1'b1, 1'b0);
    cyc(3'b000, 0, 0, 0, 2'd0, 1'b0, 1'b0);
    repeat (2) cyc(3'b000, 0, 0, 0, 2'd0, 1'b1, 1'b0);

    // Out-of-range select: nothing visible, nothing popped.
    cyc(3'b111, 64'hD0, 64'hD1, 64'hD2, 2'd3, 1'b1, 1'b0);
    repeat (5) cyc(3'b000, 0, 0, 0, 2'd3, 1'b1, 1'b0);
    for (int i = 0; i < NF; i++) cyc(3'b000, 0, 0, 0, 2'(i), 1'b1, 1'b0);

    // Simultaneous push and pop on FU2 keeps one entry.
    cyc(3'b100, 0, 0, 64'hB1, 2'd0, 1'b0, 1'b0);
    cyc(3'b100, 0, 0, 64'hB2, 2'd2, 1'b1, 1'b0);
    cyc(3'b000, 0, 0, 0, 2'd2, 1'b0, 1'b0);
    cyc(3'b000, 0, 0, 0, 2'd2, 1'b1, 1'b0);

    // Flush beats a same-cycle push on FU0 and pop on FU1.
    cyc(3'b010, 0, 64'hE1, 0, 2'd0, 1'b0, 1'b0);
    cyc(3'b001, 64'hE0, 0, 0, 2'd1, 1'b1, 1'b1);
    for (int i = 0; i < NF; i++) cyc(3'b000, 0, 0, 0, 2'(i), 1'b0, 1'b0);

    // Starvation count from a clean reset, then reset in mid-stream.
    do_reset();
    repeat (10) cyc(3'b000, 0, 0, 0, 2'd0, 1'b1, 1'b0);
    chk("starve_10", 64'(starve_cnt), Stats ? 64'(10) : 64'(0));
    cyc(3'b011, 64'hF0, 64'hF1, 0, 2'd0, 1'b0, 1'b0);
    cyc(3'b001, 64'hF2, 0, 0, 2'd0, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < NF; i++) cyc(3'b000, 0, 0, 0, 2'(i), 1'b1, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      r0 = {$urandom, $urandom};
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      cyc(3'($urandom_range(0, 7)), r0, r1, r2, 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));
    end
    cyc(3'b000, 0, 0, 0, 2'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vfu_mask_router.md
VFU_MASK_ROUTER -- requirements
Module: vfu_mask_router

Interface
REQ-001 Parameter NrFUs, default 3, number of functional units feeding the mask unit; legal 2..8.
REQ-002 Parameter Depth, default 2, entries per per-FU operand buffer; legal 1..8.
REQ-003 Parameter DataWidth, default 64, operand width; StrbWidth = DataWidth/8, derived.
REQ-004 Port clk_i  in  1  single clock; all state is updated on its rising edge.
REQ-005 Port rst_i  in  1  reset, asynchronous, active-high.
REQ-006 Port fu_operand_i  in  NrFUs x DataWidth  result operand from each FU toward the mask unit.
REQ-007 Port fu_operand_valid_i / fu_operand_ready_o  in/out  NrFUs  per-FU valid/ready handshake.
REQ-008 Port mask_operand_fu_i  in  max(1,$clog2(NrFUs))  index of the FU the mask unit is waiting on.
REQ-009 Port mask_operand_o / mask_operand_valid_o / mask_operand_ready_i  out/out/in  DataWidth/1/1  operand stream to the mask unit.
REQ-010 Port flush_i  in  1  synchronous clear of all buffers.
REQ-011 Port fu_mask_ready_i  in  NrFUs  per-FU readiness to consume mask_i.
REQ-012 Port mask_ready_o  out  1  readiness returned to the mask unit for mask_i.
REQ-013 Port starve_cnt_o  out  32  mask-unit starvation counter (see Configuration).

Function
REQ-014 Each FU channel SHALL own a FIFO of Depth entries with occupancy counter 0..Depth and wrapping read/write pointers.
REQ-015 fu_operand_ready_o[i] SHALL be 1 iff occupancy[i] < Depth and flush_i = 0; push on valid & ready.
REQ-016 mask_operand_o SHALL be the head of the FIFO selected by mask_operand_fu_i; mask_operand_valid_o = that FIFO is non-empty.
REQ-017 Pop SHALL occur only on the selected FIFO, on mask_operand_valid_o & mask_operand_ready_i; unselected FIFOs never pop.
REQ-018 mask_operand_fu_i >= NrFUs SHALL force mask_operand_valid_o = 0, mask_operand_o = 0, and no pop.
REQ-019 Latency: an operand pushed at edge t SHALL be visible at mask_operand_o after edge t (no combinational fall-through).
REQ-020 Simultaneous push and pop on one FIFO SHALL leave occupancy unchanged; when full, ready is 0 so push cannot coincide with a full FIFO.
REQ-021 Pointers SHALL wrap from Depth-1 to 0 for any Depth, including non-powers of two.
REQ-022 Channels SHALL preserve per-FU FIFO order; no ordering is implied across FUs.
REQ-023 flush_i SHALL empty all FIFOs at the next edge, taking priority over a same-cycle push or pop; the starvation counter is unaffected.
REQ-024 mask_ready_o SHALL be the OR of fu_mask_ready_i (combinational; the mask unit guarantees only the addressed FU asserts).
REQ-025 A change of mask_operand_fu_i SHALL take effect in the same cycle with no state side effects.

Reset
REQ-026 rst_i asserted SHALL asynchronously clear all occupancies, pointers and starve_cnt_o to 0.
REQ-027 During reset, fu_operand_ready_o = 0, mask_operand_valid_o = 0, mask_operand_o = 0.
REQ-028 Reset mid-transfer SHALL discard all buffered operands; nothing is replayed after release.

Configuration
REQ-029 Macro VFU_MASK_ROUTER_STATS_EN defined: starve_cnt_o SHALL increment each cycle with mask_operand_ready_i = 1 and mask_operand_valid_o = 0, saturating at 32'hFFFF_FFFF.
REQ-030 Macro undefined: starve_cnt_o SHALL be tied to 0 and no counter logic exists; all other behaviour identical.

Structure
REQ-031 The FU-index type and enum (MaskFUAlu = 0, MaskFUMFpu = 1, MaskFUSlide = 2) SHALL live in ara_pkg, alongside default constant MaskRouterDepth = 2.
REQ-032 One sub-module, vfu_mask_fifo (single-channel Depth-entry FIFO with count), SHALL be instantiated NrFUs times; selection/pop logic stays in the top.

Verification
REQ-033 NrFUs=3, Depth=2: push 0xA1, 0xA2 on FU1, select 1, ready=1 -> outputs 0xA1 then 0xA2 on consecutive cycles, then valid=0.
REQ-034 Fill FU0 with 2 entries, hold mask ready=0 -> fu_operand_ready_o[0]=0; one pop -> ready returns 1 next cycle.
REQ-035 Select=3 with FU0..FU2 non-empty -> valid=0, occupancies unchanged after 5 cycles.
REQ-036 FU2 holds 1 entry, push 0xB2 and pop same cycle -> occupancy stays 1, next output 0xB2.
REQ-037 Flush with push on FU0 and pop on FU1 same cycle -> all FIFOs empty next cycle, starve_cnt_o unchanged.
REQ-038 STATS_EN: ready=1, all empty for 10 cycles -> starve_cnt_o = 10; reset asserted mid-stream -> counter and valid read 0 immediately.
